// File: rtl/imem_pkg.sv
// Shared types and default constants for the instruction-memory fetch unit.
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W      = 16;
  localparam int unsigned IMEM_DEPTH       = 256;
  localparam int unsigned IMEM_INSTR_BYTES = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } fetch_state_e;

  // Index width for a byte array; never zero so a 1-byte memory still has a port.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_byte_array.sv
// Byte-wide storage with one synchronous write port and LANES combinational read lanes.
module imem_byte_array
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = IMEM_DEPTH,
  parameter int unsigned LANES = IMEM_INSTR_BYTES,
  parameter int unsigned IDX_W = idx_width(DEPTH)
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [IDX_W-1:0]            waddr,
  input  logic [7:0]                  wdata,
  input  logic [LANES-1:0][IDX_W-1:0] raddr,
  output logic [LANES-1:0][7:0]       rdata
);

  logic [7:0] mem [DEPTH];

  // Contents are deliberately not reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      rdata[i] = mem[raddr[i]];
    end
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction fetch unit: big-endian multi-byte reads with range fault and a
// one-entry registered response stage (EMPTY/FULL).
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W      = IMEM_ADDR_W,
  parameter int unsigned DEPTH       = IMEM_DEPTH,
  parameter int unsigned INSTR_BYTES = IMEM_INSTR_BYTES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [8*INSTR_BYTES-1:0] rsp_data,
  output logic                     rsp_fault,
  input  logic                     ld_en,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [7:0]               ld_data
);

  localparam int unsigned IDX_W  = idx_width(DEPTH);
  localparam int unsigned DATA_W = 8 * INSTR_BYTES;
  localparam int unsigned EXT_W  = ADDR_W + 1;

  fetch_state_e                        state;
  logic                                accept;
  logic                                fault_c;
  logic                                wr_en;
  logic [EXT_W-1:0]                    last_addr;
  logic [INSTR_BYTES-1:0][IDX_W-1:0]   lane_addr;
  logic [INSTR_BYTES-1:0][7:0]         lane_data;
  logic [DATA_W-1:0]                   word_c;

  assign req_ready = (!rsp_valid || rsp_ready) && !ld_en;
  assign accept    = req_valid && req_ready;

  // One extra bit so a request near the top of the address space cannot wrap to byte 0.
  assign last_addr = EXT_W'(req_addr) + EXT_W'(INSTR_BYTES - 1);
  assign fault_c   = last_addr >= EXT_W'(DEPTH);

  assign wr_en = ld_en && !rst && (EXT_W'(ld_addr) < EXT_W'(DEPTH));

  // Lane i reads byte a+i; lane 0 lands in the most significant byte.
  for (genvar i = 0; i < INSTR_BYTES; i++) begin : g_lane
    assign lane_addr[i] = IDX_W'(req_addr + ADDR_W'(i));
    assign word_c[DATA_W-1-8*i -: 8] = lane_data[i];
  end

  imem_byte_array #(
    .DEPTH (DEPTH),
    .LANES (INSTR_BYTES),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (IDX_W'(ld_addr)),
    .wdata (ld_data),
    .raddr (lane_addr),
    .rdata (lane_data)
  );

  // Output stage; accept in FULL implies rsp_ready, so new data replaces old.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_fault <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= FULL;
            rsp_valid <= 1'b1;
            rsp_data  <= fault_c ? '0 : word_c;
            rsp_fault <= fault_c;
          end
        end
        FULL: begin
          if (accept) begin
            rsp_data  <= fault_c ? '0 : word_c;
            rsp_fault <= fault_c;
          end else if (rsp_ready) begin
            state     <= EMPTY;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Randomized self-checking bench for imem_fetch_unit: default and 4-byte/64-deep instances.
module tb_imem_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance (ADDR_W=16, DEPTH=256, INSTR_BYTES=2)
  logic        req_valid = 0, rsp_ready = 0, ld_en = 0;
  logic [15:0] req_addr = 0, ld_addr = 0;
  logic [7:0]  ld_data = 0;
  logic        req_ready, rsp_valid, rsp_fault;
  logic [15:0] rsp_data;

  // Wide instance (INSTR_BYTES=4, DEPTH=64)
  logic        req_valid1 = 0, rsp_ready1 = 0, ld_en1 = 0;
  logic [15:0] req_addr1 = 0, ld_addr1 = 0;
  logic [7:0]  ld_data1 = 0;
  logic        req_ready1, rsp_valid1, rsp_fault1;
  logic [31:0] rsp_data1;

  imem_fetch_unit dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  imem_fetch_unit #(.ADDR_W(16), .DEPTH(64), .INSTR_BYTES(4)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1), .rsp_fault(rsp_fault1),
    .ld_en(ld_en1), .ld_addr(ld_addr1), .ld_data(ld_data1)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: memory image plus the response the consumer should currently see
  logic [7:0]  m_mem0 [256];
  logic        m_valid = 0, m_fault = 0, m_ready = 0, obs_ready;
  logic [15:0] m_data = 0;

  logic [7:0]  m_mem1 [64];
  logic        m_valid1 = 0, m_fault1 = 0, m_ready1 = 0, obs_ready1;
  logic [31:0] m_data1 = 0;

  function automatic void ref0(input logic [15:0] a, output logic [15:0] d, output logic f);
    int unsigned base = int'(a);
    if (base + 1 >= 256) begin d = '0; f = 1'b1; end
    else begin d = {m_mem0[base], m_mem0[base+1]}; f = 1'b0; end
  endfunction

  function automatic void ref1(input logic [15:0] a, output logic [31:0] d, output logic f);
    int unsigned base = int'(a);
    if (base + 3 >= 64) begin d = '0; f = 1'b1; end
    else begin
      d = {m_mem1[base], m_mem1[base+1], m_mem1[base+2], m_mem1[base+3]};
      f = 1'b0;
    end
  endfunction

  // One clock of stimulus on dut0; the model follows the handshake rules.
  task automatic cyc0(input logic rv, input logic [15:0] ra, input logic rr,
                      input logic le, input logic [15:0] la, input logic [7:0] ld);
    logic acc;
    req_valid = rv; req_addr = ra; rsp_ready = rr; ld_en = le; ld_addr = la; ld_data = ld;
    #1;
    m_ready   = (!m_valid || rr) && !le;
    obs_ready = req_ready;
    acc       = rv && m_ready;
    @(posedge clk);
    if (le && int'(la) < 256) m_mem0[int'(la)] = ld;
    if (acc) begin m_valid = 1'b1; ref0(ra, m_data, m_fault); end
    else if (rr) m_valid = 1'b0;
    #1;
  endtask

  task automatic cyc1(input logic rv, input logic [15:0] ra, input logic rr,
                      input logic le, input logic [15:0] la, input logic [7:0] ld);
    logic acc;
    req_valid1 = rv; req_addr1 = ra; rsp_ready1 = rr; ld_en1 = le; ld_addr1 = la; ld_data1 = ld;
    #1;
    m_ready1   = (!m_valid1 || rr) && !le;
    obs_ready1 = req_ready1;
    acc        = rv && m_ready1;
    @(posedge clk);
    if (le && int'(la) < 64) m_mem1[int'(la)] = ld;
    if (acc) begin m_valid1 = 1'b1; ref1(ra, m_data1, m_fault1); end
    else if (rr) m_valid1 = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_checks++;
    if ({rsp_valid, rsp_fault, rsp_data} !== 18'd0) begin
      n_errs++; $display("FAIL reset_outputs got=%h exp=0", {rsp_valid, rsp_fault, rsp_data});
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin n_errs++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_load();
    logic [7:0] b;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      if (i == 0) b = 8'hD1;
      if (i == 1) b = 8'h18;
      if (i == 3) b = 8'hAB;
      if (i == 4) b = 8'hCD;
      cyc0(1'b1, 16'd0, 1'b1, 1'b1, 16'(i), b);
      if (i == 0) begin
        n_checks++;
        if (obs_ready !== 1'b0 || rsp_valid !== 1'b0) begin
          n_errs++; $display("FAIL load_blocks_fetch ready=%b valid=%b exp=0,0", obs_ready, rsp_valid);
        end
      end
    end
    cyc0(1'b0, 16'd0, 1'b1, 1'b1, 16'd300, 8'hEE);
  endtask

  task automatic test_aligned_and_misaligned();
    cyc0(1'b1, 16'd0, 1'b1, 1'b0, 16'd0, 8'd0);
    n_checks++;
    if ({rsp_valid, rsp_fault, rsp_data} !== {1'b1, 1'b0, 16'hD118}) begin
      n_errs++; $display("FAIL fetch0 got v=%b f=%b d=%h exp v=1 f=0 d=d118", rsp_valid, rsp_fault, rsp_data);
    end
    cyc0(1'b1, 16'd3, 1'b1, 1'b0, 16'd0, 8'd0);
    n_checks++;
    if ({rsp_valid, rsp_fault, rsp_data} !== {1'b1, 1'b0, 16'hABCD}) begin
      n_errs++; $display("FAIL fetch3 got v=%b f=%b d=%h exp v=1 f=0 d=abcd", rsp_valid, rsp_fault, rsp_data);
    end
  endtask

  task automatic test_fault();
    logic [15:0] addrs [4];
    addrs[0] = 16'd254; addrs[1] = 16'd255; addrs[2] = 16'hFFFF; addrs[3] = 16'd256;
    for (int i = 0; i < 4; i++) begin
      cyc0(1'b1, addrs[i], 1'b1, 1'b0, 16'd0, 8'd0);
      n_checks++;
      if ({rsp_valid, rsp_fault, rsp_data} !== {1'b1, m_fault, m_data} || rsp_fault !== (i != 0)) begin
        n_errs++;
        $display("FAIL fault_addr_%h got f=%b d=%h exp f=%b d=%h", addrs[i], rsp_fault, rsp_data, m_fault, m_data);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    cyc0(1'b1, 16'd20, 1'b1, 1'b0, 16'd0, 8'd0);
    held = m_data;
    for (int i = 0; i < 3; i++) begin
      cyc0(1'b1, 16'd40, 1'b0, 1'b0, 16'd0, 8'd0);
      n_checks++;
      if (obs_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== held) begin
        n_errs++;
        $display("FAIL stall_%0d got rdy=%b v=%b d=%h exp rdy=0 v=1 d=%h", i, obs_ready, rsp_valid, rsp_data, held);
      end
    end
    cyc0(1'b1, 16'd40, 1'b1, 1'b0, 16'd0, 8'd0);
    n_checks++;
    if (obs_ready !== 1'b1 || rsp_valid !== 1'b1 || rsp_data !== m_data || m_data !== {m_mem0[40], m_mem0[41]}) begin
      n_errs++; $display("FAIL release got rdy=%b v=%b d=%h exp rdy=1 v=1 d=%h", obs_ready, rsp_valid, rsp_data, m_data);
    end
    cyc0(1'b1, 16'd41, 1'b1, 1'b0, 16'd0, 8'd0);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== m_data) begin
      n_errs++; $display("FAIL back_to_back got v=%b d=%h exp v=1 d=%h", rsp_valid, rsp_data, m_data);
    end
    cyc0(1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 8'd0);
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_errs++; $display("FAIL drain got v=%b exp v=0", rsp_valid); end
  endtask

  task automatic test_load_during_hold();
    logic [15:0] held;
    cyc0(1'b1, 16'd50, 1'b1, 1'b0, 16'd0, 8'd0);
    held = m_data;
    cyc0(1'b0, 16'd0, 1'b0, 1'b1, 16'd50, ~m_mem0[50]);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== held) begin
      n_errs++; $display("FAIL hold_under_load got v=%b d=%h exp v=1 d=%h", rsp_valid, rsp_data, held);
    end
    cyc0(1'b1, 16'd50, 1'b1, 1'b0, 16'd0, 8'd0);
    n_checks++;
    if (rsp_data !== m_data || rsp_data === held) begin
      n_errs++; $display("FAIL refetch_loaded got d=%h exp d=%h", rsp_data, m_data);
    end
  endtask

  task automatic test_random();
    logic rv, rr, le;
    logic [15:0] ra, la;
    for (int c = 0; c < 400; c++) begin
      rv = $urandom_range(0, 3) != 0;
      rr = $urandom_range(0, 3) != 0;
      le = $urandom_range(0, 7) == 0;
      ra = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      la = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(256, 65535)) : 16'($urandom_range(0, 255));
      cyc0(rv, ra, rr, le, la, 8'($urandom));
      n_checks++;
      if (obs_ready !== m_ready || rsp_valid !== m_valid) begin
        n_errs++;
        $display("FAIL rand_hs cyc=%0d got rdy=%b v=%b exp rdy=%b v=%b", c, obs_ready, rsp_valid, m_ready, m_valid);
      end
      if (m_valid) begin
        n_checks++;
        if ({rsp_fault, rsp_data} !== {m_fault, m_data}) begin
          n_errs++;
          $display("FAIL rand_rsp cyc=%0d got f=%b d=%h exp f=%b d=%h", c, rsp_fault, rsp_data, m_fault, m_data);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] saved;
    cyc0(1'b1, 16'd0, 1'b0, 1'b0, 16'd0, 8'd0);
    saved = m_mem0[0];
    #2;
    rst = 1'b1; ld_en = 1'b1; ld_addr = 16'd0; ld_data = ~saved;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_fault, rsp_data} !== 18'd0) begin
      n_errs++; $display("FAIL async_reset got %h exp 0", {rsp_valid, rsp_fault, rsp_data});
    end
    @(posedge clk); #1;
    rst = 1'b0; ld_en = 1'b0; m_valid = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_errs++; $display("FAIL post_reset got rdy=%b v=%b exp rdy=1 v=0", req_ready, rsp_valid);
    end
    cyc0(1'b1, 16'd0, 1'b1, 1'b0, 16'd0, 8'd0);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== m_data || rsp_data[15:8] !== saved) begin
      n_errs++; $display("FAIL mem_kept got v=%b d=%h exp v=1 d=%h", rsp_valid, rsp_data, m_data);
    end
  endtask

  task automatic test_wide();
    logic [7:0] b;
    for (int i = 0; i < 64; i++) begin
      b = (i >= 10 && i <= 13) ? 8'(i - 9) : 8'($urandom);
      cyc1(1'b0, 16'd0, 1'b1, 1'b1, 16'(i), b);
    end
    cyc1(1'b1, 16'd10, 1'b1, 1'b0, 16'd0, 8'd0);
    n_checks++;
    if ({rsp_valid1, rsp_fault1, rsp_data1} !== {1'b1, 1'b0, 32'h01020304}) begin
      n_errs++; $display("FAIL wide10 got v=%b f=%b d=%h exp v=1 f=0 d=01020304", rsp_valid1, rsp_fault1, rsp_data1);
    end
    for (int a = 58; a <= 62; a++) begin
      cyc1(1'b1, 16'(a), 1'b1, 1'b0, 16'd0, 8'd0);
      n_checks++;
      if ({rsp_valid1, rsp_fault1, rsp_data1} !== {1'b1, m_fault1, m_data1} || rsp_fault1 !== (a > 60)) begin
        n_errs++;
        $display("FAIL wide%0d got f=%b d=%h exp f=%b d=%h", a, rsp_fault1, rsp_data1, m_fault1, m_data1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_aligned_and_misaligned();
    test_fault();
    test_backpressure();
    test_load_during_hold();
    test_random();
    test_async_reset();
    test_wide();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
